// File: rtl/yolo_seq_pkg.sv
// Shared state encoding, default sizes and layer-table record for the YOLO layer sequencer.
package yolo_seq_pkg;
  localparam int DEF_MAX_LAYERS = 16;
  localparam int DEF_DIM_W      = 10;
  localparam int DEF_TMO_W      = 20;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, LAUNCH, WAIT, NEXT, FIN, ERR
  } state_e;

  typedef struct packed {
    logic [DEF_DIM_W-1:0] h;
    logic [DEF_DIM_W-1:0] w;
    logic [DEF_DIM_W-1:0] d;
  } layer_cfg_t;
endpackage

// File: rtl/yolo_seq_watchdog.sv
// Per-launch cycle counter; flags expiry when the cycle count reaches a non-zero limit.
module yolo_seq_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (TMO_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_inc[TMO_W-1:0];
  end

  // Post-increment compare: ERR is entered exactly `limit` cycles after LAUNCH entry.
  assign expired = en && (limit != '0) && (cnt_inc == {1'b0, limit});
endmodule

// File: rtl/yolo_layer_sequencer.sv
// Walks a layer table, launching an ap_ctrl_hs kernel once per non-empty layer,
// with a per-launch watchdog and a sticky error flag.
module yolo_layer_sequencer
  import yolo_seq_pkg::*;
#(
  parameter int  MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int  DIM_W      = DEF_DIM_W,
  parameter int  TMO_W      = DEF_TMO_W,
  localparam int AW         = $clog2(MAX_LAYERS),
  localparam int LW         = AW + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic [LW-1:0]    num_layers,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic [AW-1:0]    cfg_addr,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_d,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  input  logic             k_ap_idle,
  output logic [DIM_W-1:0] k_h,
  output logic [DIM_W-1:0] k_w,
  output logic [DIM_W-1:0] k_d,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AW-1:0]    err_layer,
  output logic [AW-1:0]    layer_idx
);
  state_e           state_q, state_d;
  logic [LW-1:0]    n_q, n_d, n_req, idx_inc;
  logic [AW-1:0]    layer_idx_q, layer_idx_d, err_layer_q, err_layer_d;
  logic [DIM_W-1:0] k_h_q, k_h_d, k_w_q, k_w_d, k_d_q, k_d_d;
  logic             error_q, error_d, done_q;
  logic             wd_clr, wd_en, wd_expired;
  logic             idle_unused;

  assign idle_unused = k_ap_idle;
  assign n_req       = (num_layers > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : num_layers;
  assign idx_inc     = LW'(layer_idx_q) + LW'(1);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    layer_idx_d = layer_idx_q;
    err_layer_d = err_layer_q;
    error_d     = error_q;
    k_h_d       = k_h_q;
    k_w_d       = k_w_q;
    k_d_d       = k_d_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          n_d         = n_req;
          layer_idx_d = '0;
          error_d     = 1'b0;
          err_layer_d = '0;
          state_d     = (n_req == '0) ? FIN : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        k_h_d   = cfg_h;
        k_w_d   = cfg_w;
        k_d_d   = cfg_d;
        // A zero dimension means an empty layer: skip without touching the kernel.
        state_d = (cfg_h == '0 || cfg_w == '0 || cfg_d == '0) ? NEXT : LAUNCH;
      end
      LAUNCH: begin
        if (k_ap_ready)                    state_d = k_ap_done ? NEXT : WAIT;
        else if (wd_expired && !k_ap_done) state_d = ERR;
      end
      WAIT: begin
        if (k_ap_done)       state_d = NEXT;
        else if (wd_expired) state_d = ERR;
      end
      NEXT: begin
        if (idx_inc == n_q) state_d = FIN;
        else begin
          layer_idx_d = idx_inc[AW-1:0];
          state_d     = FETCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ERR && state_q != ERR) begin
      error_d     = 1'b1;
      err_layer_d = layer_idx_q;
    end
  end

  assign wd_clr = (state_q == LOAD) && (state_d == LAUNCH);
  assign wd_en  = (state_q == LAUNCH) || (state_q == WAIT);

  yolo_seq_watchdog #(.TMO_W(TMO_W)) u_wd (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (timeout_cycles),
    .expired (wd_expired)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      layer_idx_q <= '0;
      err_layer_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      k_h_q       <= '0;
      k_w_q       <= '0;
      k_d_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      layer_idx_q <= layer_idx_d;
      err_layer_q <= err_layer_d;
      error_q     <= error_d;
      done_q      <= (state_q == FIN);
      k_h_q       <= k_h_d;
      k_w_q       <= k_w_d;
      k_d_q       <= k_d_d;
    end
  end

  assign cfg_addr   = layer_idx_q;
  assign layer_idx  = layer_idx_q;
  assign k_ap_start = (state_q == LAUNCH);
  assign busy       = (state_q != IDLE) && (state_q != ERR);
  assign done       = done_q;
  assign error      = error_q;
  assign err_layer  = err_layer_q;
  assign k_h        = k_h_q;
  assign k_w        = k_w_q;
  assign k_d        = k_d_q;
endmodule

// File: doc/yolo_layer_sequencer.md
YOLO_LAYER_SEQUENCER -- requirements
Module: yolo_layer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 16: layer-table depth.
REQ-002 SHALL have parameter DIM_W, default 10: width of each layer dimension (height, width, depth).
REQ-003 SHALL have parameter TMO_W, default 20: width of the watchdog counter.
REQ-004 Ports (name, direction, width, meaning):
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request.
- num_layers  in  $clog2(MAX_LAYERS)+1  layers to run.
- timeout_cycles  in  TMO_W  watchdog limit; 0 disables the watchdog.
- cfg_addr  out  $clog2(MAX_LAYERS)  layer-table read address.
- cfg_h, cfg_w, cfg_d  in  DIM_W each  table read data, 1-cycle latency.
- k_ap_start  out  1  kernel start (ap_ctrl_hs).
- k_ap_ready, k_ap_done, k_ap_idle  in  1 each  kernel status.
- k_h, k_w, k_d  out  DIM_W each  loop bounds presented to the kernel.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.
- error  out  1  sticky watchdog timeout flag.
- err_layer  out  $clog2(MAX_LAYERS)  index of the layer that timed out.
- layer_idx  out  $clog2(MAX_LAYERS)  current layer.

Function
REQ-005 FSM states SHALL be IDLE, FETCH, LOAD, LAUNCH, WAIT, NEXT, FIN, ERR.
REQ-006 IDLE, on start:
- latch n = min(num_layers, MAX_LAYERS);
- if n==0, go to FIN;
- otherwise clear layer_idx to 0 and go to FETCH.
REQ-007 FETCH SHALL drive cfg_addr=layer_idx for one cycle, then go to LOAD. cfg_addr SHALL equal layer_idx at all times.
REQ-008 LOAD SHALL register cfg_h/cfg_w/cfg_d into k_h/k_w/k_d. If any of the three is zero, go to NEXT (layer skipped, kernel not started); otherwise go to LAUNCH.
REQ-009 k_ap_start SHALL be 1 only in LAUNCH and SHALL be held until k_ap_ready is sampled 1.
REQ-010 LAUNCH, on k_ap_ready:
- go to WAIT;
- if k_ap_done is also 1 in that cycle, go directly to NEXT.
REQ-011 WAIT, on k_ap_done=1, SHALL go to NEXT. k_ap_idle is informational only.
REQ-012 Watchdog counter:
- cleared on entry to LAUNCH;
- increments every cycle in LAUNCH and WAIT;
- when it equals timeout_cycles (timeout_cycles≠0) and done/ready are not present that cycle, the FSM goes to ERR.
- done takes priority over timeout in the same cycle.
REQ-013 ERR entry SHALL set error=1, set err_layer=layer_idx, and deassert k_ap_start in the next cycle.
REQ-014 NEXT SHALL compute layer_idx+1:
- if it equals n, go to FIN;
- otherwise increment layer_idx and go to FETCH.
- No wrap occurs; layer_idx ≤ MAX_LAYERS-1.
REQ-015 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE and ERR.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In ERR, start SHALL clear error and err_layer and begin a new run exactly as from IDLE. error SHALL otherwise be sticky.
REQ-019 k_h/k_w/k_d SHALL hold their values from LOAD until the next LOAD.

Reset
REQ-020 While ap_rst_n=0, asynchronously:
- state=IDLE;
- layer_idx, cfg_addr, k_h, k_w, k_d, err_layer, watchdog = 0;
- k_ap_start, busy, done, error = 0.
REQ-021 Reset asserted mid-run SHALL drop k_ap_start immediately. After release, the block SHALL wait for a fresh start.

Structure
REQ-022 Package yolo_seq_pkg SHALL hold the state enum, the MAX_LAYERS/DIM_W/TMO_W defaults, and a layer_cfg_t struct {h,w,d}.
REQ-023 The watchdog SHALL be a sub-module yolo_seq_watchdog, with inputs clr, en, limit and output expired.

Verification
REQ-024 num_layers=3, table {(13,13,16),(26,26,32),(13,13,64)}, kernel ready after 1 cycle and done after 50 cycles:
- three launches, k_* matching each entry;
- done pulses once; busy falls in the same cycle as done.
REQ-025 num_layers=0: done pulses 2 cycles after start; k_ap_start never asserted.
REQ-026 Layer 1 entry = (0,8,8), num_layers=3: only layers 0 and 2 launched; done pulses.
REQ-027 timeout_cycles=100, kernel never returns done on layer 1:
- error=1 and err_layer=1 at cycle 100 after LAUNCH entry;
- k_ap_start=0; busy=0;
- a subsequent start clears error and restarts from layer 0.
REQ-028 k_ap_ready and k_ap_done asserted in the same cycle as the first k_ap_start: LAUNCH goes to NEXT with no WAIT cycle.
REQ-029 Reset pulsed during WAIT of layer 2: all outputs return to 0 immediately; a start issued during the run is ignored.
